// File: rtl/bus_datapath.sv
// Single-bus 32-bit CPU datapath: general registers, PC/IR/RY/MAR/HI/LO/MDR, 64-bit Z and a combinational ALU.
// Optional divider hardware is enabled by defining DATAPATH_DIVIDER_EN; otherwise DIV produces Z = 0.
module bus_datapath #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic                      Clock_i,
    input  logic                      Resetn_i,
    input  logic                      R0in_i,
    input  logic                      R1in_i,
    input  logic                      R2in_i,
    input  logic                      R3in_i,
    input  logic                      R4in_i,
    input  logic                      R5in_i,
    input  logic                      R6in_i,
    input  logic                      R7in_i,
    input  logic                      R8in_i,
    input  logic                      R9in_i,
    input  logic                      R10in_i,
    input  logic                      R11in_i,
    input  logic                      R12in_i,
    input  logic                      R13in_i,
    input  logic                      R14in_i,
    input  logic                      R15in_i,
    input  logic                      PCin_i,
    input  logic                      IRin_i,
    input  logic                      RYin_i,
    input  logic                      MARin_i,
    input  logic                      HIin_i,
    input  logic                      LOin_i,
    input  logic                      RZin_i,
    input  logic                      MDRin_i,
    input  logic                      Read_i,
    input  logic                      MDRout_i,
    input  logic                      LOout_i,
    input  logic                      HIout_i,
    input  logic                      Zhighout_i,
    input  logic                      Zlowout_i,
    input  logic                      PCout_i,
    input  logic                      R0out_i,
    input  logic                      R1out_i,
    input  logic                      R2out_i,
    input  logic                      R3out_i,
    input  logic                      R4out_i,
    input  logic                      R5out_i,
    input  logic                      R6out_i,
    input  logic                      R7out_i,
    input  logic                      R8out_i,
    input  logic                      R9out_i,
    input  logic                      R10out_i,
    input  logic                      R11out_i,
    input  logic                      R12out_i,
    input  logic                      R13out_i,
    input  logic                      R14out_i,
    input  logic                      R15out_i,
    input  logic                      ADD_i,
    input  logic                      SUB_i,
    input  logic                      MUL_i,
    input  logic                      DIV_i,
    input  logic                      SHR_i,
    input  logic                      SHL_i,
    input  logic                      ROR_i,
    input  logic                      ROL_i,
    input  logic                      AND_i,
    input  logic                      OR_i,
    input  logic                      NEGATE_i,
    input  logic                      NOT_i,
    input  logic [BITS-1:0]           Mdatain_i,
    output logic [BITS*REGISTERS-1:0] genRegisterStream_o,
    output logic [BITS-1:0]           bus_o
);

    localparam int SHW = $clog2(BITS);
    localparam logic [BITS-1:0] ZERO = '0;

    logic [15:0]       regIn;
    logic [15:0]       regOut;
    logic [BITS-1:0]   regs_q [REGISTERS];
    logic [BITS-1:0]   pc_q, ir_q, ry_q, mar_q, hi_q, lo_q, mdr_q;
    logic [2*BITS-1:0] z_q;
    logic [BITS-1:0]   mdr_d;
    logic [2*BITS-1:0] z_d;
    logic [BITS-1:0]   busValue;

    assign regIn  = {R15in_i, R14in_i, R13in_i, R12in_i, R11in_i, R10in_i, R9in_i, R8in_i,
                     R7in_i, R6in_i, R5in_i, R4in_i, R3in_i, R2in_i, R1in_i, R0in_i};
    assign regOut = {R15out_i, R14out_i, R13out_i, R12out_i, R11out_i, R10out_i, R9out_i, R8out_i,
                     R7out_i, R6out_i, R5out_i, R4out_i, R3out_i, R2out_i, R1out_i, R0out_i};

    // Later assignments win, so sources are visited from lowest to highest priority.
    always_comb begin
        busValue = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (regOut[i]) busValue = regs_q[i];
        end
        if (PCout_i)    busValue = pc_q;
        if (Zlowout_i)  busValue = z_q[BITS-1:0];
        if (Zhighout_i) busValue = z_q[2*BITS-1:BITS];
        if (HIout_i)    busValue = hi_q;
        if (LOout_i)    busValue = lo_q;
        if (MDRout_i)   busValue = mdr_q;
    end

    logic [SHW-1:0]           shamt;
    logic signed [2*BITS-1:0] opA64, opB64, product;
    logic [2*BITS-1:0]        rorFull, rolFull, divResult;

    assign shamt   = busValue[SHW-1:0];
    assign opA64   = {{BITS{ry_q[BITS-1]}}, ry_q};
    assign opB64   = {{BITS{busValue[BITS-1]}}, busValue};
    assign product = opA64 * opB64;
    assign rorFull = {ry_q, ry_q} >> shamt;
    assign rolFull = {ry_q, ry_q} << shamt;

`ifdef DATAPATH_DIVIDER_EN
    logic signed [BITS-1:0] quotient, remainder;

    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (busValue != ZERO) begin
            quotient  = $signed(ry_q) / $signed(busValue);
            remainder = $signed(ry_q) % $signed(busValue);
        end
    end

    assign divResult = (busValue == ZERO) ? {ry_q, {BITS{1'b1}}} : {remainder, quotient};
`else
    assign divResult = '0;
`endif

    // With no strobe the ALU increments the bus value, which is how PC advances.
    always_comb begin
        if (ADD_i)         z_d = {ZERO, ry_q + busValue};
        else if (SUB_i)    z_d = {ZERO, ry_q - busValue};
        else if (MUL_i)    z_d = product;
        else if (DIV_i)    z_d = divResult;
        else if (SHR_i)    z_d = {ZERO, ry_q >> shamt};
        else if (SHL_i)    z_d = {ZERO, ry_q << shamt};
        else if (ROR_i)    z_d = {ZERO, rorFull[BITS-1:0]};
        else if (ROL_i)    z_d = {ZERO, rolFull[2*BITS-1:BITS]};
        else if (AND_i)    z_d = {ZERO, ry_q & busValue};
        else if (OR_i)     z_d = {ZERO, ry_q | busValue};
        else if (NEGATE_i) z_d = {ZERO, ZERO - busValue};
        else if (NOT_i)    z_d = {ZERO, ~busValue};
        else               z_d = {ZERO, busValue + BITS'(1)};
    end

    assign mdr_d = Read_i ? Mdatain_i : busValue;

    always_ff @(posedge Clock_i or negedge Resetn_i) begin
        if (!Resetn_i) begin
            for (int i = 0; i < REGISTERS; i++) regs_q[i] <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            ry_q  <= '0;
            mar_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            mdr_q <= '0;
            z_q   <= '0;
        end else begin
            for (int i = 0; i < REGISTERS; i++) begin
                if (regIn[i]) regs_q[i] <= busValue;
            end
            if (PCin_i)  pc_q  <= busValue;
            if (IRin_i)  ir_q  <= busValue;
            if (RYin_i)  ry_q  <= busValue;
            if (MARin_i) mar_q <= busValue;
            if (HIin_i)  hi_q  <= busValue;
            if (LOin_i)  lo_q  <= busValue;
            if (MDRin_i) mdr_q <= mdr_d;
            if (RZin_i)  z_q   <= z_d;
        end
    end

    for (genvar g = 0; g < REGISTERS; g++) begin : gStream
        assign genRegisterStream_o[g*BITS +: BITS] = regs_q[g];
    end

    assign bus_o = busValue;

endmodule

// File: tb/tb_bus_datapath.sv
// Scoreboard bench for bus_datapath: directed program sequences plus randomized control words
// checked against a behavioural model of the datapath.
module tb_bus_datapath;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_DIV = 3, OP_SHR = 4, OP_SHL = 5;
    localparam int OP_ROR = 6, OP_ROL = 7, OP_AND = 8, OP_OR = 9, OP_NEG = 10, OP_NOT = 11;

    logic         clock = 1'b0;
    logic         resetn;
    logic [15:0]  rIn, rOut;
    logic         pcIn, irIn, ryIn, marIn, hiIn, loIn, rzIn, mdrIn, readSel;
    logic         mdrOut, loOut, hiOut, zhighOut, zlowOut, pcOut;
    logic [11:0]  ops;
    logic [31:0]  mdatain;
    logic [511:0] stream;
    logic [31:0]  busVal;

    always #5 clock = ~clock;

    bus_datapath dut (
        .Clock_i(clock), .Resetn_i(resetn),
        .R0in_i(rIn[0]), .R1in_i(rIn[1]), .R2in_i(rIn[2]), .R3in_i(rIn[3]),
        .R4in_i(rIn[4]), .R5in_i(rIn[5]), .R6in_i(rIn[6]), .R7in_i(rIn[7]),
        .R8in_i(rIn[8]), .R9in_i(rIn[9]), .R10in_i(rIn[10]), .R11in_i(rIn[11]),
        .R12in_i(rIn[12]), .R13in_i(rIn[13]), .R14in_i(rIn[14]), .R15in_i(rIn[15]),
        .PCin_i(pcIn), .IRin_i(irIn), .RYin_i(ryIn), .MARin_i(marIn),
        .HIin_i(hiIn), .LOin_i(loIn), .RZin_i(rzIn), .MDRin_i(mdrIn), .Read_i(readSel),
        .MDRout_i(mdrOut), .LOout_i(loOut), .HIout_i(hiOut),
        .Zhighout_i(zhighOut), .Zlowout_i(zlowOut), .PCout_i(pcOut),
        .R0out_i(rOut[0]), .R1out_i(rOut[1]), .R2out_i(rOut[2]), .R3out_i(rOut[3]),
        .R4out_i(rOut[4]), .R5out_i(rOut[5]), .R6out_i(rOut[6]), .R7out_i(rOut[7]),
        .R8out_i(rOut[8]), .R9out_i(rOut[9]), .R10out_i(rOut[10]), .R11out_i(rOut[11]),
        .R12out_i(rOut[12]), .R13out_i(rOut[13]), .R14out_i(rOut[14]), .R15out_i(rOut[15]),
        .ADD_i(ops[OP_ADD]), .SUB_i(ops[OP_SUB]), .MUL_i(ops[OP_MUL]), .DIV_i(ops[OP_DIV]),
        .SHR_i(ops[OP_SHR]), .SHL_i(ops[OP_SHL]), .ROR_i(ops[OP_ROR]), .ROL_i(ops[OP_ROL]),
        .AND_i(ops[OP_AND]), .OR_i(ops[OP_OR]), .NEGATE_i(ops[OP_NEG]), .NOT_i(ops[OP_NOT]),
        .Mdatain_i(mdatain),
        .genRegisterStream_o(stream),
        .bus_o(busVal)
    );

    // Behavioural model state
    logic [31:0] mRegs [16];
    logic [31:0] mPc, mIr, mRy, mMar, mHi, mLo, mMdr;
    logic [63:0] mZ;

    typedef struct {
        string        name;
        logic [31:0]  busExp;
        logic [511:0] streamExp;
    } ExpEntry;

    ExpEntry expQ[$];
    ExpEntry monEntry;
    logic    monValid = 1'b0;
    int      testsRun = 0;
    int      testsFailed = 0;

    function automatic logic [31:0] rotateRight(input logic [31:0] x, input int n);
        logic [31:0] v = x;
        for (int k = 0; k < n; k++) v = {v[0], v[31:1]};
        return v;
    endfunction

    function automatic logic [63:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [11:0] op);
        int     amt = int'(b[4:0]);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q, r, p;
        if (op[OP_ADD]) return {32'h0, a + b};
        if (op[OP_SUB]) return {32'h0, a - b};
        if (op[OP_MUL]) begin
            p = sa * sb;
            return p;
        end
        if (op[OP_DIV]) begin
`ifdef DATAPATH_DIVIDER_EN
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
`else
            return 64'h0;
`endif
        end
        if (op[OP_SHR]) return {32'h0, a >> amt};
        if (op[OP_SHL]) return {32'h0, a << amt};
        if (op[OP_ROR]) return {32'h0, rotateRight(a, amt)};
        if (op[OP_ROL]) return {32'h0, rotateRight(a, (32 - amt) % 32)};
        if (op[OP_AND]) return {32'h0, a & b};
        if (op[OP_OR])  return {32'h0, a | b};
        if (op[OP_NEG]) return {32'h0, 32'h0 - b};
        if (op[OP_NOT]) return {32'h0, ~b};
        return {32'h0, b + 32'h1};
    endfunction

    function automatic logic [31:0] modelBus();
        if (mdrOut)   return mMdr;
        if (loOut)    return mLo;
        if (hiOut)    return mHi;
        if (zhighOut) return mZ[63:32];
        if (zlowOut)  return mZ[31:0];
        if (pcOut)    return mPc;
        for (int i = 15; i >= 0; i--) if (rOut[i]) return mRegs[i];
        return 32'h0;
    endfunction

    function automatic logic [511:0] modelStream();
        logic [511:0] s = '0;
        for (int i = 0; i < 16; i++) s[i*32 +: 32] = mRegs[i];
        return s;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mRegs[i] = 32'h0;
        {mPc, mIr, mRy, mMar, mHi, mLo, mMdr} = '0;
        mZ = 64'h0;
    endtask

    task automatic modelClockEdge();
        logic [31:0] b;
        logic [63:0] alu;
        if (!resetn) return;
        b   = modelBus();
        alu = aluModel(mRy, b, ops);
        if (mdrIn) mMdr = readSel ? mdatain : b;
        for (int i = 0; i < 16; i++) if (rIn[i]) mRegs[i] = b;
        if (pcIn)  mPc  = b;
        if (irIn)  mIr  = b;
        if (ryIn)  mRy  = b;
        if (marIn) mMar = b;
        if (hiIn)  mHi  = b;
        if (loIn)  mLo  = b;
        if (rzIn)  mZ   = alu;
    endtask

    task automatic clearControls();
        rIn = '0; rOut = '0; ops = '0; mdatain = '0;
        {pcIn, irIn, ryIn, marIn, hiIn, loIn, rzIn, mdrIn, readSel} = '0;
        {mdrOut, loOut, hiOut, zhighOut, zlowOut, pcOut} = '0;
    endtask

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called just after a rising edge with controls already driven: queues the expected bus
    // and register stream for this cycle, then advances the model across the next edge.
    task automatic applyStimulus(input string name, input bit useConst, input logic [31:0] constExp);
        ExpEntry e;
        e.name      = name;
        e.busExp    = useConst ? constExp : modelBus();
        e.streamExp = modelStream();
        expQ.push_back(e);
        monValid = 1'b1;
        @(negedge clock);
        #1 monValid = 1'b0;
        @(posedge clock);
        modelClockEdge();
        #1 clearControls();
    endtask

    task automatic loadReg(input int idx, input logic [31:0] val);
        readSel = 1'b1; mdrIn = 1'b1; mdatain = val;
        applyStimulus("mdr_fill", 1'b0, 32'h0);
        mdrOut = 1'b1; rIn[idx] = 1'b1;
        applyStimulus($sformatf("load_r%0d", idx), 1'b1, val);
    endtask

    task automatic loadRy(input logic [31:0] val);
        readSel = 1'b1; mdrIn = 1'b1; mdatain = val;
        applyStimulus("mdr_fill", 1'b0, 32'h0);
        mdrOut = 1'b1; ryIn = 1'b1;
        applyStimulus("load_ry", 1'b1, val);
    endtask

    // Runs the ALU with RY = a and bus = b (through R3), then reads back Z low and Z high.
    task automatic aluCase(input string name, input logic [31:0] a, input logic [31:0] b,
                           input int opIdx, input logic [31:0] expLo, input logic [31:0] expHi);
        loadRy(a);
        loadReg(3, b);
        rOut[3] = 1'b1; ops[opIdx] = 1'b1; rzIn = 1'b1;
        applyStimulus({name, "_exec"}, 1'b1, b);
        zlowOut = 1'b1;
        applyStimulus({name, "_lo"}, 1'b1, expLo);
        zhighOut = 1'b1;
        applyStimulus({name, "_hi"}, 1'b1, expHi);
    endtask

    always @(negedge clock) begin
        if (monValid) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry");
            end else begin
                monEntry = expQ.pop_front();
                checkOutput({monEntry.name, "_bus"}, {480'h0, busVal}, {480'h0, monEntry.busExp});
                checkOutput({monEntry.name, "_stream"}, stream, monEntry.streamExp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearControls();
        modelReset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] reset state");
        pcOut = 1'b1;
        applyStimulus("reset_pc", 1'b1, 32'h0);
        zlowOut = 1'b1;
        applyStimulus("reset_zlow", 1'b1, 32'h0);

        $display("[TB] register loads");
        loadReg(2, 32'h22);
        loadReg(4, 32'h24);
        loadReg(5, 32'h26);
        rOut[2] = 1'b1;
        applyStimulus("read_r2", 1'b1, 32'h22);

        $display("[TB] AND instruction");
        pcOut = 1'b1; marIn = 1'b1; rzIn = 1'b1;
        applyStimulus("t0", 1'b1, 32'h0);
        zlowOut = 1'b1; pcIn = 1'b1; readSel = 1'b1; mdrIn = 1'b1; mdatain = 32'h4A92_0000;
        applyStimulus("t1", 1'b1, 32'h1);
        mdrOut = 1'b1; irIn = 1'b1;
        applyStimulus("t2", 1'b1, 32'h4A92_0000);
        rOut[2] = 1'b1; ryIn = 1'b1;
        applyStimulus("t3", 1'b1, 32'h22);
        rOut[4] = 1'b1; ops[OP_AND] = 1'b1; rzIn = 1'b1;
        applyStimulus("t4", 1'b1, 32'h24);
        zlowOut = 1'b1; rIn[5] = 1'b1;
        applyStimulus("t5", 1'b1, 32'h20);
        rOut[5] = 1'b1;
        applyStimulus("r5_after_and", 1'b1, 32'h20);
        pcOut = 1'b1;
        applyStimulus("pc_after_t1", 1'b1, 32'h1);

        $display("[TB] MUL / DIV / shifts");
        aluCase("mul", 32'hFFFF_FFFE, 32'h3, OP_MUL, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
        zhighOut = 1'b1; hiIn = 1'b1;
        applyStimulus("hi_load", 1'b1, 32'hFFFF_FFFF);
        zlowOut = 1'b1; loIn = 1'b1;
        applyStimulus("lo_load", 1'b1, 32'hFFFF_FFFA);
        hiOut = 1'b1;
        applyStimulus("hi_read", 1'b1, 32'hFFFF_FFFF);
        loOut = 1'b1;
        applyStimulus("lo_read", 1'b1, 32'hFFFF_FFFA);
`ifdef DATAPATH_DIVIDER_EN
        aluCase("div", 32'h7, 32'h2, OP_DIV, 32'h3, 32'h1);
        aluCase("div0", 32'h5, 32'h0, OP_DIV, 32'hFFFF_FFFF, 32'h5);
        aluCase("divneg", 32'hFFFF_FFF9, 32'h2, OP_DIV, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
`else
        aluCase("div", 32'h7, 32'h2, OP_DIV, 32'h0, 32'h0);
        aluCase("div0", 32'h5, 32'h0, OP_DIV, 32'h0, 32'h0);
`endif
        aluCase("ror", 32'h1, 32'h1, OP_ROR, 32'h8000_0000, 32'h0);
        aluCase("shr", 32'h8000_0000, 32'd33, OP_SHR, 32'h4000_0000, 32'h0);
        aluCase("rol0", 32'h1234_5678, 32'h0, OP_ROL, 32'h1234_5678, 32'h0);
        aluCase("neg", 32'h0, 32'h5, OP_NEG, 32'hFFFF_FFFB, 32'h0);

        $display("[TB] bus priority");
        loadReg(3, 32'h5);
        loadReg(7, 32'h9);
        rOut[3] = 1'b1; rOut[7] = 1'b1;
        applyStimulus("prio_r7_over_r3", 1'b1, 32'h9);
        applyStimulus("bus_idle", 1'b1, 32'h0);

        $display("[TB] asynchronous reset");
        loadReg(5, 32'h20);
        pcOut = 1'b1;
        #1 resetn = 1'b0;
        modelReset();
        applyStimulus("async_rst_pc", 1'b1, 32'h0);
        zlowOut = 1'b1;
        applyStimulus("async_rst_z", 1'b1, 32'h0);
        rOut[5] = 1'b1;
        applyStimulus("async_rst_r5", 1'b1, 32'h0);
        resetn = 1'b1;

        $display("[TB] randomized control words");
        for (int n = 0; n < 400; n++) begin
            rIn     = 16'($urandom & $urandom & $urandom);
            rOut    = 16'($urandom & $urandom & $urandom & $urandom);
            pcIn    = ($urandom_range(0, 5) == 0);
            irIn    = ($urandom_range(0, 5) == 0);
            ryIn    = ($urandom_range(0, 2) == 0);
            marIn   = ($urandom_range(0, 5) == 0);
            hiIn    = ($urandom_range(0, 4) == 0);
            loIn    = ($urandom_range(0, 4) == 0);
            rzIn    = ($urandom_range(0, 1) == 0);
            mdrIn   = ($urandom_range(0, 2) == 0);
            readSel = ($urandom_range(0, 1) == 0);
            mdrOut   = ($urandom_range(0, 5) == 0);
            loOut    = ($urandom_range(0, 7) == 0);
            hiOut    = ($urandom_range(0, 7) == 0);
            zhighOut = ($urandom_range(0, 6) == 0);
            zlowOut  = ($urandom_range(0, 5) == 0);
            pcOut    = ($urandom_range(0, 7) == 0);
            mdatain  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 2) != 0) ops[$urandom_range(0, 11)] = 1'b1;
            if ($urandom_range(0, 4) == 0) ops[$urandom_range(0, 11)] = 1'b1;
            applyStimulus($sformatf("rand%0d", n), 1'b0, 32'h0);
        end

        @(negedge clock);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/bus_datapath.md
Name: bus_datapath

Overview:
- Single-bus 32-bit CPU datapath: sixteen general registers R0–R15, plus PC, IR, RY, MAR, HI, LO, MDR and a 64-bit Z result register, all sharing one 32-bit bus.
- A combinational ALU takes RY (operand A) and the bus (operand B) and writes Z.
- The block sits under the external control unit, which drives every enable and operation strobe; Mdatain stands in for memory read data.

Parameters:
- BITS, 32, word width of every register and the bus.
- REGISTERS, 16, number of general registers.

Ports:
- Clock  input  1  rising-edge clock for every register.
- Resetn  input  1  asynchronous active-low reset; clears every register.
- R0in..R15in  input  1 each  load general register Rn from the bus.
- PCin, IRin, RYin, MARin, HIin, LOin  input  1 each  load the named register from the bus.
- RZin  input  1  load the 64-bit Z register from the ALU result.
- MDRin  input  1  load MDR.
- Read  input  1  MDR source select: 1 = Mdatain, 0 = bus.
- MDRout, LOout, HIout, Zhighout, Zlowout, PCout  input  1 each  drive the named register onto the bus.
- R15out..R0out  input  1 each  drive Rn onto the bus.
- ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT  input  1 each  ALU operation strobes.
- Mdatain  input  32  memory read data.
- genRegisterStream  output  BITS*REGISTERS  concatenation {R15,…,R0}; R0 occupies bits [31:0].
- bus  output  32  current bus value.

Behaviour:
- Reset: while Resetn is low, asynchronously clear all registers to 0: R0–R15, PC, IR, RY, MAR, HI, LO, MDR and Z (64 bits). Consequently bus = 0 and genRegisterStream = 0.
- Registers: every register loads on the rising Clock edge when its in-enable is high; otherwise it holds. R0 is an ordinary register.
- MDR: D-input = Read ? Mdatain : bus, loaded when MDRin is high.
- Bus driver: combinational, fixed priority when several out-enables are high: MDRout > LOout > HIout > Zhighout > Zlowout > PCout > R15out > … > R0out. With no out-enable high, bus = 0.
- Operands: A = RY, B = bus. Result is a 64-bit {hi,lo}.
- Operations (hi = 0 unless stated otherwise):
  - ADD: lo = A+B. SUB: lo = A−B. Both mod 2^32; carry and borrow are discarded.
  - AND / OR: bitwise.
  - NOT: lo = ~B. NEGATE: lo = −B (two's complement).
  - SHR: logical right shift of A by B[4:0]. SHL: left shift of A by B[4:0]. ROR / ROL: rotate A by B[4:0]. An amount of 0 passes A unchanged.
  - MUL: signed 32×32 → {hi,lo} full 64-bit product.
  - DIV: signed divide; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Divide by zero: lo = 32'hFFFFFFFF, hi = A.
- No strobe asserted: lo = B+1, hi = 0. This implements PC increment (PCout + RZin).
- Multiple strobes asserted: priority ADD > SUB > MUL > DIV > SHR > SHL > ROR > ROL > AND > OR > NEGATE > NOT.
- Timing: the ALU is combinational; the result is captured in Z on the edge where RZin is high. Zlowout drives Z[31:0] and Zhighout drives Z[63:32].
- Read-modify-write: a register may both drive and load the bus in the same cycle; it captures the value present before the edge.
- Reset mid-operation: all state clears immediately; control must restart its sequence.

Optional Feature:
- Macro DATAPATH_DIVIDER_EN.
- Defined: DIV behaves as specified above.
- Undefined: no divider hardware is built; asserting DIV yields Z = 0 and participates in the priority chain as usual.

Test Plan:
- Register load: Mdatain = 0x22, Read + MDRin for one cycle, then MDRout + R2in → R2 = 0x22 and genRegisterStream[95:64] = 0x22. Repeat for R4 = 0x24 and R5 = 0x26.
- AND instruction:
  - T0: PCout + MARin + RZin with no strobe, PC = 0 → Z = 1.
  - T1: Zlowout + PCin → PC = 1; Read + MDRin with Mdatain = 0x4A920000 → MDR = 0x4A920000.
  - T2: MDRout + IRin → IR = 0x4A920000.
  - T3: R2out + RYin → RY = 0x22.
  - T4: R4out + AND + RZin → Z = 0x20.
  - T5: Zlowout + R5in → R5 = 0x20.
- MUL/DIV:
  - RY = 0xFFFFFFFE, bus = 3, MUL → Z = 0xFFFFFFFF_FFFFFFFA; then Zhighout + HIin and Zlowout + LOin → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - RY = 7, bus = 2, DIV → lo = 3, hi = 1.
  - RY = 5, bus = 0, DIV → lo = 0xFFFFFFFF, hi = 5.
- Shifts: RY = 1, bus = 1, ROR → lo = 0x80000000. RY = 0x80000000, bus = 33, SHR → lo = 0x40000000 (amount = B[4:0] = 1).
- Bus priority: R3 = 5, R7 = 9; assert R3out and R7out → bus = 9. Deassert all out-enables → bus = 0.
- Asynchronous reset: pulse Resetn low between clock edges while R5 = 0x20 → R5, PC and Z read 0 immediately, before the next edge.
